// File: rtl/sar_scan_ctrl_if.sv
// ============================================================================
// Module   : sar_scan_ctrl_if
// Brief    : SAR-side and result-stream signals of the scan sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface sar_scan_ctrl_if #(
    parameter int Width = 6,
    parameter int ChanW = 2
) ();
    logic [ChanW-1:0] mux_sel_o;
    logic             sar_start_o;
    logic             sar_eoc_i;
    logic [Width-1:0] sar_result_i;
    logic [Width-1:0] data_o;
    logic [ChanW-1:0] data_chan_o;
    logic             data_valid_o;
    logic             data_ready_i;

    modport master (
        output mux_sel_o, sar_start_o, data_o, data_chan_o, data_valid_o,
        input  sar_eoc_i, sar_result_i, data_ready_i
    );

    modport slave (
        input  mux_sel_o, sar_start_o, data_o, data_chan_o, data_valid_o,
        output sar_eoc_i, sar_result_i, data_ready_i
    );
endinterface

`default_nettype wire

// File: rtl/sar_scan_ctrl.sv
// ============================================================================
// Module   : sar_scan_ctrl
// Brief    : Masked channel scan, settle, SAR start and per-channel averaging.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module sar_scan_ctrl #(
    parameter int Width         = 6,
    parameter int Channels      = 4,
    parameter int ChanW         = 2,
    parameter int AvgLog2       = 2,
    parameter int SettleCycles  = 3,
    parameter int TimeoutCycles = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                enable_i,
    input  logic                single_i,
    input  logic [Channels-1:0] chan_mask_i,
    sar_scan_ctrl_if.master     bus,
    output logic                busy_o,
    output logic                scan_done_o,
    output logic                timeout_o
);

    localparam int c_acc_w = Width + AvgLog2;
    localparam int c_cnt_w = AvgLog2 + 1;
    localparam int c_set_w = $clog2(SettleCycles + 1);
    localparam int c_tmo_w = $clog2(TimeoutCycles + 1);
    localparam logic [c_cnt_w-1:0] c_num_avg = c_cnt_w'(2 ** AvgLog2);
    localparam logic [c_set_w-1:0] c_settle  = c_set_w'(SettleCycles);
    localparam logic [c_tmo_w-1:0] c_tmo_max = c_tmo_w'(TimeoutCycles - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_START  = 3'd2,
        ST_WAIT   = 3'd3,
        ST_OUT    = 3'd4,
        ST_NEXT   = 3'd5
    } state_e;

    state_e                state_q,     state_d;
    logic [c_set_w-1:0]    settle_q,    settle_d;
    logic [c_tmo_w-1:0]    tmo_q,       tmo_d;
    logic [c_acc_w-1:0]    acc_q,       acc_d;
    logic [c_cnt_w-1:0]    cnt_q,       cnt_d;
    logic [Channels-1:0]   mask_q,      mask_d;
    logic [ChanW-1:0]      mux_sel_q,   mux_sel_d;
    logic [Width-1:0]      data_q,      data_d;
    logic [ChanW-1:0]      data_chan_q, data_chan_d;
    logic                  timeout_q,   timeout_d;

    logic                  w_scan_done;
    logic [ChanW:0]        w_next_hit;
    logic [ChanW:0]        w_low_hit;
    logic [c_acc_w-1:0]    w_acc_sum;
    logic [c_cnt_w-1:0]    w_cnt_inc;

    // Returns {found, index} of the lowest set bit at or above 'from'.
    function automatic logic [ChanW:0] first_set(input logic [Channels-1:0] mask,
                                                 input int from);
        logic [ChanW:0] hit;
        hit = '0;
        for (int i = Channels - 1; i >= 0; i--) begin
            if (mask[i] && (i >= from)) hit = {1'b1, ChanW'(i)};
        end
        return hit;
    endfunction

    always_comb begin
        state_d     = state_q;
        settle_d    = settle_q;
        tmo_d       = tmo_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        mask_d      = mask_q;
        mux_sel_d   = mux_sel_q;
        data_d      = data_q;
        data_chan_d = data_chan_q;
        timeout_d   = timeout_q;
        w_scan_done = 1'b0;
        w_next_hit  = first_set(mask_q, int'(mux_sel_q) + 1);
        w_low_hit   = first_set(chan_mask_i, 0);
        w_acc_sum   = acc_q + c_acc_w'(bus.sar_result_i);
        w_cnt_inc   = cnt_q + c_cnt_w'(1);

        case (state_q)
            ST_IDLE: begin
                acc_d = '0;
                cnt_d = '0;
                if (enable_i && w_low_hit[ChanW]) begin
                    mask_d    = chan_mask_i;
                    mux_sel_d = w_low_hit[ChanW-1:0];
                    settle_d  = c_settle;
                    state_d   = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (settle_q <= c_set_w'(1)) begin
                    settle_d = '0;
                    state_d  = ST_START;
                end else begin
                    settle_d = settle_q - c_set_w'(1);
                end
            end
            ST_START: begin
                tmo_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.sar_eoc_i) begin
                    acc_d = w_acc_sum;
                    cnt_d = w_cnt_inc;
                    if (w_cnt_inc == c_num_avg) begin
                        data_d      = Width'(w_acc_sum >> AvgLog2);
                        data_chan_d = mux_sel_q;
                        state_d     = ST_OUT;
                    end else begin
                        state_d = ST_START;
                    end
                end else if (tmo_q == c_tmo_max) begin
                    // Stuck SAR: drop the partial average and move on.
                    timeout_d = 1'b1;
                    acc_d     = '0;
                    cnt_d     = '0;
                    state_d   = ST_NEXT;
                end else begin
                    tmo_d = tmo_q + c_tmo_w'(1);
                end
            end
            ST_OUT: begin
                if (bus.data_ready_i) state_d = ST_NEXT;
            end
            ST_NEXT: begin
                acc_d    = '0;
                cnt_d    = '0;
                settle_d = c_settle;
                state_d  = ST_SETTLE;
                if (w_next_hit[ChanW]) begin
                    mux_sel_d = w_next_hit[ChanW-1:0];
                end else if (single_i) begin
                    w_scan_done = 1'b1;
                    mux_sel_d   = '0;
                    state_d     = ST_IDLE;
                end else begin
                    mask_d = chan_mask_i;
                    if (w_low_hit[ChanW]) begin
                        mux_sel_d = w_low_hit[ChanW-1:0];
                    end else begin
                        mux_sel_d = '0;
                        state_d   = ST_IDLE;
                    end
                end
                if (!enable_i) begin
                    mux_sel_d = '0;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            settle_q    <= '0;
            tmo_q       <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            mask_q      <= '0;
            mux_sel_q   <= '0;
            data_q      <= '0;
            data_chan_q <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            settle_q    <= settle_d;
            tmo_q       <= tmo_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            mask_q      <= mask_d;
            mux_sel_q   <= mux_sel_d;
            data_q      <= data_d;
            data_chan_q <= data_chan_d;
            timeout_q   <= timeout_d;
        end
    end

    assign bus.mux_sel_o    = mux_sel_q;
    assign bus.sar_start_o  = (state_q == ST_START);
    assign bus.data_o       = data_q;
    assign bus.data_chan_o  = data_chan_q;
    assign bus.data_valid_o = (state_q == ST_OUT);
    assign busy_o           = (state_q != ST_IDLE);
    assign scan_done_o      = w_scan_done;
    assign timeout_o        = timeout_q;

endmodule

`default_nettype wire
